wb_regbank_param: RTL and testbench

Parametrised Wishbone classic slave register bank, the configurable successor to the fixed three-register 8-bit slave. It provides NREGS registers of DW bits with byte-lane selects and a per-register access mode: read/write control, read-only status, or sticky write-1-to-clear event. It also supports a configurable number of wait states and a level interrupt built from the event registers. It sits on the ECP5 test Wishbone bus between the bus master and SDR control/status logic.

---
 rtl/wb_regbank_param_if.sv | 25 ++
 rtl/wb_regbank_param.sv | 147 ++++++++++++++
 tb/tb_wb_regbank_param.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regbank_param_if.sv
// Wishbone classic request/response bundle for wb_regbank_param.
// The master drives the request fields; the slave returns read data and a one-cycle ack.
interface wb_regbank_param_if #(
  parameter int DW = 8,
  parameter int AW = 8
) ();
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_we_i;
  logic [AW-1:0]   wb_adr_i;
  logic [DW/8-1:0] wb_sel_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_regbank_param.sv
// Wishbone classic register bank of NREGS x DW with RW / RO-status / sticky W1C-event registers and a level irq.
// Ack follows the request edge by 1+WAIT_STATES edges; the master stalls by holding cyc/stb until ack, dropping cyc aborts.
module wb_regbank_param #(
  parameter int                    DW          = 8,
  parameter int                    AW          = 8,
  parameter int                    NREGS       = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NREGS-1:0]      RO_MASK     = '0,
  parameter logic [NREGS-1:0]      W1C_MASK    = '0,
  parameter logic [NREGS*DW-1:0]   RST_VAL     = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  wb_regbank_param_if.slave     bus,
  input  logic [NREGS*DW-1:0]   status_i,
  input  logic [NREGS*DW-1:0]   event_i,
  output logic [NREGS*DW-1:0]   ctrl_o,
  output logic                  irq_o
);

  localparam int NLANES = DW / 8;

  typedef logic [NREGS-1:0][DW-1:0] bank_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  function automatic logic [NREGS*DW-1:0] expand_mask(input logic [NREGS-1:0] m);
    logic [NREGS*DW-1:0] r;
    r = '0;
    for (int n = 0; n < NREGS; n++) r[n*DW +: DW] = {DW{m[n]}};
    return r;
  endfunction

  // A register flagged both RO and W1C behaves as RO.
  localparam logic [NREGS-1:0]    W1C_EFF  = W1C_MASK & ~RO_MASK;
  localparam logic [NREGS*DW-1:0] RO_BITS  = expand_mask(RO_MASK);
  localparam logic [NREGS*DW-1:0] W1C_BITS = expand_mask(W1C_EFF);
  localparam logic [NREGS*DW-1:0] RST_IMG  = RST_VAL & ~RO_BITS & ~W1C_BITS;

  state_t              state;
  logic [2:0]          wait_cnt;
  logic                lat_we;
  logic [AW-1:0]       lat_adr;
  logic [NLANES-1:0]   lat_sel;
  logic [DW-1:0]       lat_dat;
  bank_t               regs_q;
  bank_t               regs_d;
  logic                irq_q;
  logic                irq_d;
  logic                ack_q;
  logic [DW-1:0]       dat_q;
  logic [DW-1:0]       rd_data;
  logic [DW-1:0]       lane_mask;
  logic                commit;
  logic [NREGS*DW-1:0] event_set;
  logic [NREGS*DW-1:0] reg_view;

  assign commit    = (state == S_ACK) && bus.wb_cyc_i;
  assign event_set = event_i & W1C_BITS;
  // RO slices of regs_q are held at zero, so OR-ing in status gives the read image.
  assign reg_view  = regs_q | (status_i & RO_BITS);

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NLANES; k++) lane_mask[k*8 +: 8] = {8{lat_sel[k]}};
  end

  always_comb begin
    rd_data = '1;
    for (int n = 0; n < NREGS; n++) begin
      if (lat_adr == AW'(n)) rd_data = reg_view[n*DW +: DW];
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int n = 0; n < NREGS; n++) begin
      if (commit && lat_we && (lat_adr == AW'(n))) begin
        if (W1C_EFF[n]) begin
          regs_d[n] = regs_q[n] & ~(lat_dat & lane_mask);
        end else if (!RO_MASK[n]) begin
          regs_d[n] = (regs_q[n] & ~lane_mask) | (lat_dat & lane_mask);
        end
      end
    end
    // Event set is applied after the clear so a coincident set wins.
    regs_d = regs_d | event_set;
    irq_d  = |(regs_d & W1C_BITS);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      lat_we   <= 1'b0;
      lat_adr  <= '0;
      lat_sel  <= '0;
      lat_dat  <= '0;
      regs_q   <= RST_IMG;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      regs_q <= regs_d;
      irq_q  <= irq_d;
      ack_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.wb_cyc_i && bus.wb_stb_i) begin
            lat_we  <= bus.wb_we_i;
            lat_adr <= bus.wb_adr_i;
            lat_sel <= bus.wb_sel_i;
            lat_dat <= bus.wb_dat_i;
            if (WAIT_STATES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= 3'(WAIT_STATES - 1);
            end else begin
              state <= S_ACK;
            end
          end
        end
        S_WAIT: begin
          if (!bus.wb_cyc_i) begin
            state <= S_IDLE;
          end else if (wait_cnt == 3'd0) begin
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          if (bus.wb_cyc_i) begin
            ack_q <= 1'b1;
            dat_q <= rd_data;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;
  assign ctrl_o       = regs_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_wb_regbank_param.sv
// Bench for wb_regbank_param: two instances (0 and 3 wait states) against a register-map model,
// with a scoreboard queue per instance popped by a monitor on every ack.
module tb_wb_regbank_param;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NREGS = 8;
  localparam logic [NREGS-1:0]    RO_MASK  = 8'b0000_0010;
  localparam logic [NREGS-1:0]    W1C_MASK = 8'b0010_1010;
  localparam logic [NREGS*DW-1:0] RST_VAL  = {32'h0000_0000, 32'h0000_0000, 32'hCAFE_0005, 32'h1234_5678,
                                              32'h0000_0033, 32'hA5A5_0000, 32'h5555_5555, 32'h0000_0000};

  typedef struct {
    bit            rd;
    logic [DW-1:0] dat;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NREGS*DW-1:0] status;
  logic [NREGS*DW-1:0] ev;
  logic [NREGS*DW-1:0] ctrl0, ctrl3;
  logic irq0, irq3;

  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  exp_t sbq0[$];
  exp_t sbq1[$];
  logic [DW-1:0] mdl [2][NREGS];
  bit   prev_ack [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  wb_regbank_param_if #(.DW(DW), .AW(AW)) bus0 ();
  wb_regbank_param_if #(.DW(DW), .AW(AW)) bus3 ();

  wb_regbank_param #(.DW(DW), .AW(AW), .NREGS(NREGS), .WAIT_STATES(0),
                     .RO_MASK(RO_MASK), .W1C_MASK(W1C_MASK), .RST_VAL(RST_VAL)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus0),
    .status_i(status), .event_i(ev), .ctrl_o(ctrl0), .irq_o(irq0));

  wb_regbank_param #(.DW(DW), .AW(AW), .NREGS(NREGS), .WAIT_STATES(3),
                     .RO_MASK(RO_MASK), .W1C_MASK(W1C_MASK), .RST_VAL(RST_VAL)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus3),
    .status_i(status), .event_i(ev), .ctrl_o(ctrl3), .irq_o(irq3));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic ack_of(input int d);
    return (d == 0) ? bus0.wb_ack_o : bus3.wb_ack_o;
  endfunction

  function automatic logic [DW-1:0] dat_of(input int d);
    return (d == 0) ? bus0.wb_dat_o : bus3.wb_dat_o;
  endfunction

  function automatic logic [NREGS*DW-1:0] ctrl_of(input int d);
    return (d == 0) ? ctrl0 : ctrl3;
  endfunction

  function automatic logic irq_of(input int d);
    return (d == 0) ? irq0 : irq3;
  endfunction

  function automatic bit is_w1c(input int a);
    return W1C_MASK[a] && !RO_MASK[a];
  endfunction

  // Register-map model: what a read of index a should return right now.
  function automatic logic [DW-1:0] mdl_read(input int d, input int a);
    if (a >= NREGS) return '1;
    if (RO_MASK[a]) return status[a*DW +: DW];
    return mdl[d][a];
  endfunction

  function automatic logic [NREGS*DW-1:0] exp_ctrl(input int d);
    logic [NREGS*DW-1:0] r;
    r = '0;
    for (int n = 0; n < NREGS; n++) r[n*DW +: DW] = RO_MASK[n] ? '0 : mdl[d][n];
    return r;
  endfunction

  function automatic logic exp_irq(input int d);
    logic r;
    r = 1'b0;
    for (int n = 0; n < NREGS; n++) if (is_w1c(n) && (mdl[d][n] != '0)) r = 1'b1;
    return r;
  endfunction

  task automatic mdl_write(input int d, input int a, input logic [3:0] sel, input logic [DW-1:0] dat);
    logic [DW-1:0] m;
    if (a >= NREGS || RO_MASK[a]) return;
    m = '0;
    for (int k = 0; k < DW/8; k++) if (sel[k]) m[k*8 +: 8] = 8'hFF;
    if (is_w1c(a)) mdl[d][a] = mdl[d][a] & ~(dat & m);
    else           mdl[d][a] = (mdl[d][a] & ~m) | (dat & m);
  endtask

  task automatic mdl_event(input logic [NREGS*DW-1:0] vec);
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < NREGS; n++)
        if (is_w1c(n)) mdl[d][n] = mdl[d][n] | vec[n*DW +: DW];
  endtask

  task automatic mdl_reset();
    logic [NREGS*DW-1:0] rv;
    rv = RST_VAL;
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < NREGS; n++)
        mdl[d][n] = (RO_MASK[n] || is_w1c(n)) ? '0 : rv[n*DW +: DW];
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input int d);
    chk($sformatf("ctrl%0d", d), ctrl_of(d), exp_ctrl(d));
    chk($sformatf("irq%0d", d), {255'b0, irq_of(d)}, {255'b0, exp_irq(d)});
  endtask

  task automatic drive(input int d, input bit c, input bit we, input int a,
                       input logic [3:0] sel, input logic [DW-1:0] dat);
    if (d == 0) begin
      bus0.wb_cyc_i = c; bus0.wb_stb_i = c; bus0.wb_we_i = we;
      bus0.wb_adr_i = AW'(a); bus0.wb_sel_i = sel; bus0.wb_dat_i = dat;
    end else begin
      bus3.wb_cyc_i = c; bus3.wb_stb_i = c; bus3.wb_we_i = we;
      bus3.wb_adr_i = AW'(a); bus3.wb_sel_i = sel; bus3.wb_dat_i = dat;
    end
  endtask

  // Issue one access, queue its expected response, hold the request until ack.
  task automatic xfer(input int d, input bit we, input int a, input logic [3:0] sel, input logic [DW-1:0] dat);
    exp_t e;
    bit   got;
    @(negedge clk);
    drive(d, 1'b1, we, a, sel, dat);
    e.rd  = !we;
    e.dat = we ? '0 : mdl_read(d, a);
    e.cyc = cyc_cnt + 2 + ws_of(d);
    if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
    if (we) mdl_write(d, a, sel, dat);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ack_of(d);
    end
    drive(d, 1'b0, 1'b0, 0, 4'h0, '0);
    if (!got) begin
      chk("ack_timeout", 0, 1);
      if (d == 0) void'(sbq0.pop_back()); else void'(sbq1.pop_back());
    end
  endtask

  task automatic pulse_event(input logic [NREGS*DW-1:0] vec);
    @(negedge clk);
    ev = vec;
    @(negedge clk);
    ev = '0;
    mdl_event(vec);
  endtask

  task automatic on_ack(input int d);
    exp_t e;
    int   n;
    n = (d == 0) ? sbq0.size() : sbq1.size();
    if (n == 0) begin
      chk($sformatf("unexpected_ack%0d", d), 1, 0);
      return;
    end
    if (d == 0) e = sbq0.pop_front(); else e = sbq1.pop_front();
    chk($sformatf("ack_latency%0d", d), cyc_cnt, e.cyc);
    if (e.rd) chk($sformatf("read_data%0d", d), dat_of(d), e.dat);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack_of(d) === 1'b1) begin
        chk($sformatf("ack_gap%0d", d), {255'b0, prev_ack[d]}, 0);
        on_ack(d);
      end
      prev_ack[d] = (ack_of(d) === 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREGS*DW-1:0] vec;
    int nack;
    rst_n = 1'b0;
    ev    = '0;
    for (int n = 0; n < NREGS; n++) status[n*DW +: DW] = 32'h0BAD_0000 | n;
    status[1*DW +: DW] = 32'hDEAD_BEEF;
    drive(0, 1'b0, 1'b0, 0, 4'h0, '0);
    drive(1, 1'b0, 1'b0, 0, 4'h0, '0);
    repeat (3) @(negedge clk);
    mdl_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ack%0d", d), {255'b0, ack_of(d)}, 0);
      chk($sformatf("rst_dat%0d", d), dat_of(d), 0);
      check_state(d);
    end
    rst_n = 1'b1;

    xfer(0, 1'b0, 2, 4'hF, '0);
    check_state(0);
    xfer(0, 1'b1, 0, 4'b0101, 32'h1122_3344);
    xfer(0, 1'b0, 0, 4'hF, '0);

    vec = '0;
    vec[3*DW + 5] = 1'b1;
    pulse_event(vec);
    check_state(0);
    xfer(0, 1'b0, 3, 4'hF, '0);
    xfer(0, 1'b1, 3, 4'hF, 32'h20);
    check_state(0);

    // Clear lands on the same edge as a new event on the same bit.
    fork
      xfer(0, 1'b1, 3, 4'hF, 32'h20);
      begin
        @(negedge clk);
        @(posedge clk); #1 ev = vec;
        @(posedge clk); #1 ev = '0;
      end
    join
    mdl_event(vec);
    check_state(0);
    check_state(1);
    xfer(0, 1'b0, 3, 4'hF, '0);

    xfer(0, 1'b1, 1, 4'hF, 32'h0);
    xfer(0, 1'b0, 1, 4'hF, '0);
    xfer(0, 1'b0, NREGS, 4'hF, '0);
    xfer(0, 1'b1, NREGS + 1, 4'hF, 32'h7777_7777);
    check_state(0);

    xfer(1, 1'b0, 4, 4'hF, '0);

    @(negedge clk);
    drive(1, 1'b1, 1'b1, 0, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 0, 4'h0, '0);
    nack = 0;
    repeat (8) begin @(negedge clk); if (ack_of(1) === 1'b1) nack++; end
    chk("abort_no_ack", nack, 0);
    check_state(1);

    @(negedge clk);
    drive(1, 1'b1, 1'b1, 2, 4'hF, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 0, 4'h0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    nack = 0;
    repeat (8) begin @(negedge clk); if (ack_of(1) === 1'b1) nack++; end
    chk("reset_no_ack", nack, 0);
    check_state(0);
    check_state(1);
    xfer(1, 1'b0, 2, 4'hF, '0);

    for (int it = 0; it < 200; it++) begin
      int d;
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) begin
        for (int w = 0; w < NREGS; w++) vec[w*DW +: DW] = $urandom & $urandom;
        pulse_event(vec);
      end else begin
        xfer(d, 1'($urandom_range(0, 1)), $urandom_range(0, NREGS + 1),
             4'($urandom_range(0, 15)), $urandom);
      end
      check_state(0);
      check_state(1);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq0.size() + sbq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
